// File: rtl/keypad_code_entry.sv
// rtl/keypad_code_entry.sv - keypad digit accumulator, code submit, fail counting and lockout
//
// Ports:
//   clk           in   clock, all state on rising edge
//   rst_n         in   asynchronous active-low reset
//   key_valid     in   high while a debounced key is held
//   key_code[3:0] in   0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC-4'hF ignored
//   door_open     in   door-unlocked indication from the lock FSM
//   access_code   out  registered code, stable from SUBMIT until the next ENTER
//   validate_code out  one-cycle code-check request (high in SUBMIT)
//   entry_error   out  one-cycle pulse on a bad entry or inactivity timeout
//   locked        out  high throughout LOCKOUT
//   entry_state   out  current state encoding
//   digit_count   out  digits captured (0..2)
module keypad_code_entry #(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int RESULT_WAIT    = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       door_open,
    output logic [3:0] access_code,
    output logic       validate_code,
    output logic       entry_error,
    output logic       locked,
    output logic [2:0] entry_state,
    output logic [1:0] digit_count
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] ENTRY       = 3'd1;
    localparam logic [2:0] SUBMIT      = 3'd2;
    localparam logic [2:0] WAIT_RESULT = 3'd3;
    localparam logic [2:0] DOOR_OPEN   = 3'd4;
    localparam logic [2:0] LOCKOUT     = 3'd5;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST    = 8'(RESULT_WAIT - 1);
    localparam logic [7:0] LOCK_LAST    = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0] FAIL_LIMIT   = 4'(MAX_FAILS);

    logic [2:0] state_q, state_d;
    logic       key_valid_q;
    logic [6:0] acc_q, acc_d;
    logic [1:0] digits_q, digits_d;
    // One counter serves the inactivity timer, result wait and lockout;
    // it is only ever meaningful within a single state.
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] fails_q, fails_d;
    logic [3:0] code_q, code_d;
    logic       err_q, err_d;

    logic       press;
    logic       is_digit;
    logic       is_enter;
    logic       is_clear;
    logic       accepted;
    logic [3:0] fails_inc;

    assign press     = key_valid & ~key_valid_q;
    assign is_digit  = (key_code <= 4'd9);
    assign is_enter  = (key_code == 4'hA);
    assign is_clear  = (key_code == 4'hB);
    // Keys C-F never count as presses, so they do not reset the timer.
    assign accepted  = press & (is_digit | is_enter | is_clear);
    assign fails_inc = fails_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        fails_d  = fails_q;
        code_d   = code_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (press && is_digit) begin
                    acc_d    = {3'b000, key_code};
                    digits_d = 2'd1;
                    cnt_d    = 8'd0;
                    state_d  = ENTRY;
                end
            end
            ENTRY: begin
                // A press wins over a timeout landing in the same cycle.
                if (accepted) begin
                    cnt_d = 8'd0;
                    if (is_digit) begin
                        if (digits_q == 2'd1) begin
                            acc_d    = acc_q * 7'd10 + {3'b000, key_code};
                            digits_d = 2'd2;
                        end else begin
                            err_d    = 1'b1;
                            acc_d    = 7'd0;
                            digits_d = 2'd0;
                            state_d  = IDLE;
                        end
                    end else if (is_enter) begin
                        if (acc_q > 7'd15) begin
                            err_d    = 1'b1;
                            acc_d    = 7'd0;
                            digits_d = 2'd0;
                            state_d  = IDLE;
                        end else begin
                            code_d  = acc_q[3:0];
                            acc_d   = 7'd0;
                            state_d = SUBMIT;
                        end
                    end else begin
                        acc_d    = 7'd0;
                        digits_d = 2'd0;
                        state_d  = IDLE;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d    = 1'b1;
                    acc_d    = 7'd0;
                    digits_d = 2'd0;
                    cnt_d    = 8'd0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SUBMIT: begin
                digits_d = 2'd0;
                cnt_d    = 8'd0;
                state_d  = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                if (door_open) begin
                    fails_d = 4'd0;
                    cnt_d   = 8'd0;
                    state_d = DOOR_OPEN;
                end else if (cnt_q == WAIT_LAST) begin
                    fails_d = fails_inc;
                    cnt_d   = 8'd0;
                    state_d = (fails_inc == FAIL_LIMIT) ? LOCKOUT : IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DOOR_OPEN: begin
                if (!door_open) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (cnt_q == LOCK_LAST) begin
                    fails_d = 4'd0;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_valid_q <= 1'b0;
            acc_q       <= 7'd0;
            digits_q    <= 2'd0;
            cnt_q       <= 8'd0;
            fails_q     <= 4'd0;
            code_q      <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid;
            acc_q       <= acc_d;
            digits_q    <= digits_d;
            cnt_q       <= cnt_d;
            fails_q     <= fails_d;
            code_q      <= code_d;
            err_q       <= err_d;
        end
    end

    assign access_code   = code_q;
    assign validate_code = (state_q == SUBMIT);
    assign entry_error   = err_q;
    assign locked        = (state_q == LOCKOUT);
    assign entry_state   = state_q;
    assign digit_count   = digits_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// tb/tb_keypad_code_entry.sv - directed self-checking bench for keypad_code_entry
module tb_keypad_code_entry;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       door_open;
    logic [3:0] access_code;
    logic       validate_code;
    logic       entry_error;
    logic       locked;
    logic [2:0] entry_state;
    logic [1:0] digit_count;

    int tests;
    int fails;

    keypad_code_entry dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .door_open     (door_open),
        .access_code   (access_code),
        .validate_code (validate_code),
        .entry_error   (entry_error),
        .locked        (locked),
        .entry_state   (entry_state),
        .digit_count   (digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Key down for exactly one rising edge, released afterwards (no edge yet).
    task automatic press_hold(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        press_hold(k);
        tick();
    endtask

    initial begin
        int n;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        key_valid = 1'b0;
        key_code = 4'd0;
        door_open = 1'b0;
        #12;
        check("rst_state", 8'(entry_state), 8'd0);
        check("rst_code", 8'(access_code), 8'd0);
        check("rst_valid", 8'(validate_code), 8'd0);
        check("rst_err", 8'(entry_error), 8'd0);
        check("rst_locked", 8'(locked), 8'd0);
        check("rst_digits", 8'(digit_count), 8'd0);
        rst_n = 1'b1;
        tick();

        // 1: code 9 accepted, door opens 2 cycles after validate
        press(4'd9);
        check("t1_digits", 8'(digit_count), 8'd1);
        press_hold(4'hA);
        check("t1_state_submit", 8'(entry_state), 8'd2);
        check("t1_validate", 8'(validate_code), 8'd1);
        check("t1_code", 8'(access_code), 8'd9);
        check("t1_no_err", 8'(entry_error), 8'd0);
        tick();
        check("t1_state_wait", 8'(entry_state), 8'd3);
        check("t1_validate_low", 8'(validate_code), 8'd0);
        tick();
        door_open = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t1_state_door", 8'(entry_state), 8'd4);
        end
        door_open = 1'b0;
        tick();
        check("t1_idle", 8'(entry_state), 8'd0);
        check("t1_fails", 8'(dut.fails_q), 8'd0);

        // 2: code 12 rejected after exactly 4 wait cycles
        press(4'd1);
        press(4'd2);
        press_hold(4'hA);
        check("t2_validate", 8'(validate_code), 8'd1);
        check("t2_code", 8'(access_code), 8'd12);
        tick();
        n = 0;
        while (entry_state == 3'd3 && n < 20) begin
            n++;
            tick();
        end
        check("t2_wait_cycles", 8'(n), 8'd4);
        check("t2_idle", 8'(entry_state), 8'd0);
        check("t2_fails", 8'(dut.fails_q), 8'd1);
        check("t2_locked", 8'(locked), 8'd0);

        // 3: out-of-range code and third digit both error
        press(4'd1);
        press(4'd6);
        press_hold(4'hA);
        check("t3_err16", 8'(entry_error), 8'd1);
        check("t3_no_valid", 8'(validate_code), 8'd0);
        check("t3_idle16", 8'(entry_state), 8'd0);
        tick();
        check("t3_err_pulse", 8'(entry_error), 8'd0);
        press(4'd1);
        press(4'd2);
        check("t3_two_digits", 8'(digit_count), 8'd2);
        press_hold(4'd3);
        check("t3_err3", 8'(entry_error), 8'd1);
        check("t3_digits0", 8'(digit_count), 8'd0);
        check("t3_idle3", 8'(entry_state), 8'd0);
        tick();

        // 4: three rejected submits -> 64-cycle lockout
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) begin
            press(4'd0);
            press_hold(4'hA);
            check("t4_validate", 8'(validate_code), 8'd1);
            for (int i = 0; i < 5; i++) tick();
            check("t4_state", 8'(entry_state), (r == 2) ? 8'd5 : 8'd0);
        end
        check("t4_locked", 8'(locked), 8'd1);
        n = 0;
        key_code = 4'd5;
        while (locked && n < 100) begin
            n++;
            key_valid = n[0];
            tick();
        end
        key_valid = 1'b0;
        check("t4_lock_cycles", 8'(n), 8'd64);
        check("t4_idle", 8'(entry_state), 8'd0);
        check("t4_digits", 8'(digit_count), 8'd0);
        check("t4_fails", 8'(dut.fails_q), 8'd0);
        tick();

        // 5: held key is one press, then inactivity timeout
        key_valid = 1'b1;
        key_code = 4'd5;
        tick();
        check("t5_digits_press", 8'(digit_count), 8'd1);
        for (int i = 0; i < 9; i++) tick();
        key_valid = 1'b0;
        check("t5_digits_held", 8'(digit_count), 8'd1);
        check("t5_state_entry", 8'(entry_state), 8'd1);
        n = 9;
        while (!entry_error && n < 100) begin
            tick();
            n++;
        end
        check("t5_timeout_cycles", 8'(n), 8'd32);
        check("t5_idle", 8'(entry_state), 8'd0);
        check("t5_digits0", 8'(digit_count), 8'd0);
        tick();

        // 6: async reset mid-cycle during WAIT_RESULT
        press(4'd7);
        press_hold(4'hA);
        check("t6_code", 8'(access_code), 8'd7);
        tick();
        check("t6_wait", 8'(entry_state), 8'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", 8'(entry_state), 8'd0);
        check("t6_rst_code", 8'(access_code), 8'd0);
        check("t6_rst_valid", 8'(validate_code), 8'd0);
        check("t6_rst_err", 8'(entry_error), 8'd0);
        check("t6_rst_locked", 8'(locked), 8'd0);
        check("t6_rst_digits", 8'(digit_count), 8'd0);
        rst_n = 1'b1;
        tick();
        check("t6_idle", 8'(entry_state), 8'd0);
        press(4'd4);
        press_hold(4'hA);
        check("t6_validate", 8'(validate_code), 8'd1);
        check("t6_code4", 8'(access_code), 8'd4);
        tick();
        door_open = 1'b1;
        tick();
        check("t6_door", 8'(entry_state), 8'd4);
        door_open = 1'b0;
        tick();
        check("t6_final_idle", 8'(entry_state), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
